// File: rtl/draw_sequencer.sv
// Two-pass frame sequencer (erase in black, logic/increment, colour) and pixel
// arbiter serving NCH plot clients in front of the VGA adapter.
module draw_sequencer #(
  parameter int NCH       = 3,
  parameter int SELW      = 2,
  parameter int CW        = 20,
  parameter int XW        = 10,
  parameter int LOGIC_TMO = 30
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_tick,
  input  logic [NCH-1:0]    ch_en,
  input  logic [NCH*CW-1:0] dly_in,
  input  logic              logic_done,
  input  logic [NCH*XW-1:0] x_in,
  input  logic [NCH*XW-1:0] y_in,
  input  logic [NCH*3-1:0]  colour_in,
  input  logic [NCH-1:0]    wr_in,
  output logic [NCH-1:0]    go,
  output logic [SELW-1:0]   sel,
  output logic              iscolour,
  output logic              logic_go,
  output logic              inc_enable,
  output logic [XW-1:0]     x,
  output logic [XW-1:0]     y,
  output logic [2:0]        colour,
  output logic              writeEn,
  output logic              busy,
  output logic              frame_done,
  output logic              overrun
);

  typedef enum logic [2:0] {
    IDLE, LOAD, DRAW, NEXT, LOGIC, LOGIC_WAIT, INC, SWAP
  } state_t;

  state_t          state_q, state_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic [NCH-1:0]  mask_q, mask_d;
  logic [NCH-1:0]  go_q, go_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            iscolour_q, iscolour_d;
  logic            logic_go_q, logic_go_d;
  logic            inc_enable_q, inc_enable_d;
  logic            busy_q, busy_d;
  logic            frame_done_q, frame_done_d;
  logic            overrun_q, overrun_d;

  logic [SELW:0]   first_en, first_mask, next_mask;
  logic [CW-1:0]   dly_sel;
  logic            pix_active;
  logic [2:0]      colour_raw;

  // Lowest set bit of m at index >= lo; MSB of the result flags "found".
  function automatic logic [SELW:0] pick(input logic [NCH-1:0] m, input int lo);
    logic [SELW:0] r;
    r = '0;
    for (int i = NCH - 1; i >= 0; i--)
      if (m[i] && i >= lo) r = {1'b1, SELW'(i)};
    return r;
  endfunction

  always_comb begin
    first_en   = pick(ch_en, 0);
    first_mask = pick(mask_q, 0);
    next_mask  = pick(mask_q, int'(sel_q) + 1);
    dly_sel    = '0;
    for (int i = 0; i < NCH; i++)
      if (sel_q == SELW'(i)) dly_sel = dly_in[i*CW +: CW];
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    mask_d     = mask_q;
    cnt_d      = cnt_q;
    iscolour_d = iscolour_q;
    overrun_d  = overrun_q | (frame_tick && (state_q != IDLE));
    case (state_q)
      IDLE: begin
        if (frame_tick) begin
          mask_d     = ch_en;
          iscolour_d = 1'b0;
          sel_d      = first_en[SELW-1:0];
          state_d    = first_en[SELW] ? LOAD : LOGIC;
        end
      end
      LOAD: begin
        cnt_d   = '0;
        state_d = DRAW;
      end
      DRAW: begin
        // Budget compared live so a client can shorten or stretch its slot.
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == dly_sel) state_d = NEXT;
      end
      NEXT: begin
        if (next_mask[SELW]) begin
          sel_d   = next_mask[SELW-1:0];
          state_d = LOAD;
        end else begin
          state_d = iscolour_q ? SWAP : LOGIC;
        end
      end
      LOGIC: begin
        cnt_d   = '0;
        state_d = LOGIC_WAIT;
      end
      LOGIC_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (logic_done || (cnt_q == CW'(LOGIC_TMO - 1))) state_d = INC;
      end
      INC: begin
        iscolour_d = 1'b1;
        sel_d      = first_mask[SELW-1:0];
        state_d    = first_mask[SELW] ? LOAD : SWAP;
      end
      SWAP: begin
        iscolour_d = 1'b0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Strobes are registered from the next state so they line up with it.
    for (int i = 0; i < NCH; i++)
      go_d[i] = (state_d == LOAD) && (sel_d == SELW'(i));
    logic_go_d   = (state_d == LOGIC);
    inc_enable_d = (state_d == INC);
    frame_done_d = (state_d == SWAP);
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      mask_q       <= '0;
      go_q         <= '0;
      cnt_q        <= '0;
      iscolour_q   <= 1'b0;
      logic_go_q   <= 1'b0;
      inc_enable_q <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      mask_q       <= mask_d;
      go_q         <= go_d;
      cnt_q        <= cnt_d;
      iscolour_q   <= iscolour_d;
      logic_go_q   <= logic_go_d;
      inc_enable_q <= inc_enable_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
    end
  end

  // Pixel path: only the served channel in LOAD/DRAW may plot.
  always_comb begin
    pix_active = (state_q == LOAD) || (state_q == DRAW);
    x          = x_in[XW-1:0];
    y          = y_in[XW-1:0];
    colour_raw = colour_in[2:0];
    writeEn    = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (pix_active && (sel_q == SELW'(i))) begin
        x          = x_in[i*XW +: XW];
        y          = y_in[i*XW +: XW];
        colour_raw = colour_in[i*3 +: 3];
        writeEn    = wr_in[i];
      end
    end
    colour = iscolour_q ? colour_raw : 3'b000;
  end

  assign go         = go_q;
  assign sel        = sel_q;
  assign iscolour   = iscolour_q;
  assign logic_go   = logic_go_q;
  assign inc_enable = inc_enable_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_draw_sequencer.sv
// Bench for draw_sequencer: a frame-trace model checked every cycle, plus
// directed frames with hand-computed event timings.
`timescale 1ns/1ps
module tb_draw_sequencer;
  localparam int NCH = 3, SELW = 2, CW = 20, XW = 10, TMO = 30;

  logic clk = 1'b0;
  logic rst;
  logic frame_tick, logic_done;
  logic [NCH-1:0]    ch_en, wr_in;
  logic [NCH*CW-1:0] dly_in;
  logic [NCH*XW-1:0] x_in, y_in;
  logic [NCH*3-1:0]  colour_in;
  logic [NCH-1:0]    go;
  logic [SELW-1:0]   sel;
  logic              iscolour, logic_go, inc_enable, writeEn, busy, frame_done, overrun;
  logic [XW-1:0]     x, y;
  logic [2:0]        colour;

  always #5 clk = ~clk;

  draw_sequencer #(.NCH(NCH), .SELW(SELW), .CW(CW), .XW(XW), .LOGIC_TMO(TMO)) dut (
    .clk(clk), .reset(rst), .frame_tick(frame_tick), .ch_en(ch_en), .dly_in(dly_in),
    .logic_done(logic_done), .x_in(x_in), .y_in(y_in), .colour_in(colour_in), .wr_in(wr_in),
    .go(go), .sel(sel), .iscolour(iscolour), .logic_go(logic_go), .inc_enable(inc_enable),
    .x(x), .y(y), .colour(colour), .writeEn(writeEn), .busy(busy),
    .frame_done(frame_done), .overrun(overrun)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected output of one busy cycle.
  typedef struct {
    logic [NCH-1:0] go;
    int             sel;
    logic           isc;
    logic           lgo;
    logic           inc;
    logic           fd;
    logic           pix;
  } ent_t;

  ent_t q[$];

  function automatic ent_t mk(input logic [NCH-1:0] g, input int s, input logic isc,
                              input logic lgo, input logic inc, input logic fd, input logic pix);
    ent_t e;
    e.go = g; e.sel = s; e.isc = isc; e.lgo = lgo; e.inc = inc; e.fd = fd; e.pix = pix;
    return e;
  endfunction

  // One drawing pass: per enabled channel a go cycle, budget+1 draw cycles, one gap cycle.
  task automatic push_pass(input logic [NCH-1:0] m, input logic isc);
    for (int c = 0; c < NCH; c++) begin
      if (m[c]) begin
        int d;
        logic [NCH-1:0] oh;
        oh = '0;
        oh[c] = 1'b1;
        d = int'(dly_in[c*CW +: CW]);
        q.push_back(mk(oh, c, isc, 1'b0, 1'b0, 1'b0, 1'b1));
        for (int k = 0; k <= d; k++) q.push_back(mk('0, c, isc, 1'b0, 1'b0, 1'b0, 1'b1));
        q.push_back(mk('0, c, isc, 1'b0, 1'b0, 1'b0, 1'b0));
      end
    end
  endtask

  ent_t cur;
  logic have, s_tick, s_ld;
  logic prev_busy = 1'b0;
  logic m_ovr = 1'b0;
  logic waiting = 1'b0;
  logic [NCH-1:0] m_mask = '0;
  int wcnt = 0;

  // Model step and comparison, once per cycle just after the active edge.
  always begin
    @(posedge clk);
    s_tick = frame_tick;
    s_ld   = logic_done;
    #1;
    have = 1'b0;
    cur  = mk('0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    if (rst) begin
      q.delete();
      waiting = 1'b0;
      m_ovr   = 1'b0;
    end else begin
      if (prev_busy && s_tick) m_ovr = 1'b1;
      if (waiting) begin
        if (wcnt > 0 && (s_ld || wcnt == TMO)) begin
          waiting = 1'b0;
          q.push_back(mk('0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
          push_pass(m_mask, 1'b1);
          q.push_back(mk('0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        end else begin
          wcnt++;
          have = 1'b1;
        end
      end else if (!prev_busy && s_tick) begin
        m_mask = ch_en;
        push_pass(ch_en, 1'b0);
        q.push_back(mk('0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
      end
      if (!have && q.size() > 0) begin
        cur  = q.pop_front();
        have = 1'b1;
        if (cur.lgo) begin
          waiting = 1'b1;
          wcnt    = 0;
        end
      end
    end
    prev_busy = have;

    chk("busy", 32'(busy), 32'(have));
    chk("go", 32'(go), 32'(cur.go));
    chk("logic_go", 32'(logic_go), 32'(cur.lgo));
    chk("inc_enable", 32'(inc_enable), 32'(cur.inc));
    chk("frame_done", 32'(frame_done), 32'(cur.fd));
    chk("overrun", 32'(overrun), 32'(m_ovr));
    chk("writeEn", 32'(writeEn), 32'(cur.pix ? wr_in[cur.sel] : 1'b0));
    if (cur.pix) begin
      chk("sel", 32'(sel), 32'(cur.sel));
      chk("iscolour", 32'(iscolour), 32'(cur.isc));
      chk("x", 32'(x), 32'(x_in[cur.sel*XW +: XW]));
      chk("y", 32'(y), 32'(y_in[cur.sel*XW +: XW]));
      chk("colour", 32'(colour), 32'(cur.isc ? colour_in[cur.sel*3 +: 3] : 3'b000));
    end
    if (!have) chk("iscolour_idle", 32'(iscolour), 32'd0);
  end

  // Event recorder: times relative to the first busy cycle of the latest frame.
  int fc = 0, lgo_t = -1, inc_t = -1, fd_t = -1, we_cnt = 0;
  int ev_go_t[$];
  logic [NCH-1:0] ev_go_v[$];
  logic busy_d1 = 1'b0;
  logic [2:0] col1 = '0, col84 = '0;

  always begin
    @(posedge clk);
    #2;
    if (busy && !busy_d1) begin
      fc = 0;
      ev_go_t.delete();
      ev_go_v.delete();
      lgo_t = -1; inc_t = -1; fd_t = -1; we_cnt = 0;
    end else begin
      fc++;
    end
    if (go != '0) begin
      ev_go_t.push_back(fc);
      ev_go_v.push_back(go);
    end
    if (logic_go) lgo_t = fc;
    if (inc_enable) inc_t = fc;
    if (frame_done) fd_t = fc;
    if (writeEn) we_cnt++;
    if (fc == 1) col1 = colour;
    if (fc == 84) col84 = colour;
    busy_d1 = busy;
  end

  // which: 0 = frame_done, 1 = logic_go
  task automatic wait_pulse(input int which, input int budget);
    int n;
    n = 0;
    while (!(which == 0 ? frame_done : logic_go) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(which == 0 ? "wait_frame_done" : "wait_logic_go",
        32'(which == 0 ? frame_done : logic_go), 32'd1);
  endtask

  function automatic int count_go(input logic [NCH-1:0] v);
    int n;
    n = 0;
    foreach (ev_go_v[i]) if (ev_go_v[i] == v) n++;
    return n;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_t[6];
    logic [NCH-1:0] exp_v[6];
    exp_t = '{0, 7, 18, 83, 90, 101};
    exp_v = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

    rst = 1'b1; frame_tick = 1'b0; logic_done = 1'b0;
    ch_en = '0; wr_in = '0; dly_in = '0; x_in = '0; y_in = '0; colour_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_go", 32'(go), 32'd0);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_iscolour", 32'(iscolour), 32'd0);
    chk("rst_writeEn", 32'(writeEn), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    rst = 1'b0;
    x_in = {10'd300, 10'd200, 10'd100};
    y_in = {10'd30, 10'd20, 10'd10};
    colour_in = {3'b011, 3'b101, 3'b111};
    wr_in = 3'b111;
    repeat (5) @(negedge clk);
    chk("idle_no_tick", 32'(busy), 32'd0);

    // Frame 1: all channels, budgets 4/8/30, logic_done never arrives.
    ch_en = 3'b111;
    dly_in = {20'd30, 20'd8, 20'd4};
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    wait_pulse(0, 400);
    @(negedge clk);
    chk("f1_ngo", 32'(ev_go_t.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < ev_go_t.size()) begin
        chk("f1_go_time", 32'(ev_go_t[i]), 32'(exp_t[i]));
        chk("f1_go_val", 32'(ev_go_v[i]), 32'(exp_v[i]));
      end
    end
    chk("f1_logic_go_t", 32'(lgo_t), 32'd51);
    chk("f1_inc_t", 32'(inc_t), 32'd82);
    chk("f1_tmo_gap", 32'(inc_t - lgo_t), 32'(TMO + 1));
    chk("f1_frame_done_t", 32'(fd_t), 32'd134);
    chk("f1_we_cycles", 32'(we_cnt), 32'd96);
    chk("f1_erase_colour", 32'(col1), 32'd0);
    chk("f1_paint_colour", 32'(col84), 32'd7);
    chk("f1_overrun", 32'(overrun), 32'd0);

    // Frame 2: channel 1 disabled, early logic_done, tick mid-DRAW.
    ch_en = 3'b101;
    dly_in = {20'd2, 20'd7, 20'd1};
    wr_in = 3'b011;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    wait_pulse(1, 100);
    @(negedge clk);
    @(negedge clk);
    logic_done = 1'b1;
    @(negedge clk);
    logic_done = 1'b0;
    wait_pulse(0, 100);
    @(negedge clk);
    chk("f2_go_ch0", 32'(count_go(3'b001)), 32'd2);
    chk("f2_go_ch1", 32'(count_go(3'b010)), 32'd0);
    chk("f2_go_ch2", 32'(count_go(3'b100)), 32'd2);
    chk("f2_logic_go_t", 32'(lgo_t), 32'd9);
    chk("f2_inc_t", 32'(inc_t), 32'd12);
    chk("f2_frame_done_t", 32'(fd_t), 32'd22);
    chk("f2_we_cycles", 32'(we_cnt), 32'd6);
    chk("f2_overrun", 32'(overrun), 32'd1);
    repeat (10) @(negedge clk);
    chk("f2_no_second_frame", 32'(busy), 32'd0);
    chk("f2_overrun_sticky", 32'(overrun), 32'd1);

    // Frame 3: empty mask, tick during SWAP.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("f3_overrun_cleared", 32'(overrun), 32'd0);
    ch_en = 3'b000;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    wait_pulse(1, 20);
    @(negedge clk);
    @(negedge clk);
    logic_done = 1'b1;
    @(negedge clk);
    logic_done = 1'b0;
    wait_pulse(0, 20);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
    chk("f3_ngo", 32'(ev_go_t.size()), 32'd0);
    chk("f3_logic_go_t", 32'(lgo_t), 32'd0);
    chk("f3_inc_t", 32'(inc_t), 32'd3);
    chk("f3_frame_done_t", 32'(fd_t), 32'd4);
    chk("f3_swap_tick_overrun", 32'(overrun), 32'd1);
    chk("f3_swap_tick_ignored", 32'(busy), 32'd0);

    // Frame 4: asynchronous reset in the middle of channel 1's DRAW.
    ch_en = 3'b111;
    dly_in = {20'd30, 20'd8, 20'd4};
    wr_in = 3'b111;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (10) @(negedge clk);
    chk("f4_drawing", 32'(writeEn), 32'd1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("f4_arst_go", 32'(go), 32'd0);
    chk("f4_arst_busy", 32'(busy), 32'd0);
    chk("f4_arst_writeEn", 32'(writeEn), 32'd0);
    chk("f4_arst_sel", 32'(sel), 32'd0);
    chk("f4_arst_overrun", 32'(overrun), 32'd0);
    chk("f4_arst_strobes", 32'({logic_go, inc_enable, frame_done, iscolour}), 32'd0);
    chk("f4_arst_colour", 32'(colour), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("f4_idle_after_reset", 32'(busy), 32'd0);
    chk("f4_no_more_go", 32'(ev_go_t.size()), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/draw_sequencer.md
Name: draw_sequencer

Overview:
Parametrised frame sequencer and pixel arbiter for the VGA plot path. It serves NCH drawing clients (ball, bricks, platform, extras) in two passes per frame: an erase pass in black, a game-logic/increment phase, then a colour pass. Per-channel draw budgets and enables are run-time inputs, and frame overruns are flagged. It replaces the fixed three-channel draw FSM and draw mux in front of the vga_adapter wrapper.

Parameters:
NCH, 3, number of drawing clients; channel 0 is served first.
SELW, 2, width of the channel select; requires 2^SELW >= NCH.
CW, 20, width of the per-channel delay and the budget counter.
XW, 10, width of the x and y coordinates.
LOGIC_TMO, 30, maximum cycles spent in LOGIC_WAIT without logic_done.

Ports:
clk  in  1  system clock (CLOCK_50)
reset  in  1  asynchronous, active-high reset
frame_tick  in  1  frame start request (delay_counter enable gated by start)
ch_en  in  NCH  per-channel enable; sampled at frame start
dly_in  in  NCH*CW  packed per-channel draw budget; channel i occupies bits [i*CW +: CW]
logic_done  in  1  collision logic finished
x_in  in  NCH*XW  packed client x
y_in  in  NCH*XW  packed client y
colour_in  in  NCH*3  packed client colour
wr_in  in  NCH  client write enables
go  out  NCH  one-hot, one-cycle start pulse to a client
sel  out  SELW  currently served channel
iscolour  out  1  0 = erase pass, 1 = colour pass
logic_go  out  1  one-cycle collision-logic start pulse
inc_enable  out  1  one-cycle position-update pulse
x  out  XW  muxed x to VGA
y  out  XW  muxed y to VGA
colour  out  3  muxed colour; 3'b000 when iscolour=0
writeEn  out  1  muxed plot strobe
busy  out  1  high in every state except IDLE
frame_done  out  1  one-cycle pulse when a frame completes
overrun  out  1  sticky flag: frame_tick arrived while busy

Behaviour:
- Reset (asynchronous, active-high): state IDLE; go=0, sel=0, iscolour=0, logic_go=0, inc_enable=0, writeEn=0, busy=0, frame_done=0, overrun=0; budget counter=0; latched enable mask=0. Reset mid-frame aborts immediately; no further go pulses are issued.
- Reset is the only way to clear overrun.
- States: IDLE, LOAD, DRAW, NEXT, LOGIC, LOGIC_WAIT, INC, SWAP.
- IDLE:
  - On frame_tick=1, latch ch_en into the enable mask, set iscolour=0 and sel to the lowest enabled channel.
  - If the mask is nonzero, go to LOAD. If the mask is all zero, go straight to LOGIC.
- LOAD (1 cycle): go[sel]=1; budget counter cleared to 0; then DRAW.
- DRAW:
  - The counter increments by 1 each cycle. Leave for NEXT in the cycle where count == dly_in[sel] (compared live).
  - dly=0 gives exactly 1 DRAW cycle. dly=D gives D+1 DRAW cycles.
  - The counter wraps modulo 2^CW, so dly = 2^CW-1 is legal.
- NEXT (1 cycle): advance sel to the next higher enabled channel and go to LOAD.
  - If none remain and iscolour=0, go to LOGIC.
  - If none remain and iscolour=1, go to SWAP.
- LOGIC (1 cycle): logic_go=1; counter cleared; then LOGIC_WAIT.
- LOGIC_WAIT: leave for INC when logic_done=1 or count == LOGIC_TMO-1, whichever comes first.
- INC (1 cycle): inc_enable=1.
  - Set iscolour=1 and sel to the lowest enabled channel.
  - Go to LOAD; if the mask is zero, go to SWAP.
- SWAP (1 cycle): frame_done=1; iscolour cleared to 0; go to IDLE.
- Pixel mux (combinational from sel and state):
  - In LOAD and DRAW: x/y = slice sel of x_in/y_in; writeEn = wr_in[sel]; colour = colour_in slice when iscolour=1, else 3'b000.
  - In all other states: writeEn=0, and x, y, colour hold the channel-0 slice.
- Overrun: frame_tick=1 in any state other than IDLE sets overrun and is otherwise ignored. It is not queued.
- frame_tick in the same cycle as the SWAP→IDLE transition is ignored and sets overrun. A tick in IDLE starts a frame.
- ch_en changes mid-frame have no effect until the next frame.
- dly_in changes mid-DRAW take effect immediately. If count has already passed the new value, the counter wraps before matching.
- A disabled channel receives no go pulse and never drives writeEn.

Test Plan:
- NCH=3, ch_en=3'b111, dly={30,8,4}, one frame_tick → go pulses in order 1,2,4 (erase), then logic_go, inc_enable, then 1,2,4 (colour), then frame_done. DRAW lengths are 5/9/31 cycles. iscolour=0 during the first pass and 1 during the second.
- ch_en=3'b101 → channel 1 is never pulsed and sel skips it. Per frame, exactly two go[0] and two go[2] pulses.
- Erase pass with colour_in[0]=3'b111 and wr_in[0]=1 → colour=000 and writeEn=1 during DRAW of channel 0. In the colour pass, colour=111.
- logic_done held 0 → inc_enable asserts exactly LOGIC_TMO+1 cycles after logic_go. With logic_done=1 two cycles after logic_go, inc_enable asserts on the following cycle.
- frame_tick pulsed mid-DRAW → overrun=1 and stays 1 after frame_done. No second frame starts until the next tick in IDLE.
- Reset asserted asynchronously mid-DRAW → all outputs are 0 before the next clock edge. After release, the sequencer stays in IDLE until frame_tick.
